// File: rtl/timer_digits_pkg.sv
// Package: timer_digits_pkg
// Purpose: shared definitions for the countdown timer slice: the FSM state
//          encoding, the BCD wrap constants, and a zero-time helper.
// Ports:   none (package).
package timer_digits_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Value a digit takes when it wraps while borrowing.
  localparam logic [3:0] BCD_NINE = 4'd9;  // ones digits and minute tens
  localparam logic [3:0] BCD_FIVE = 4'd5;  // seconds tens digit

  // True when the packed MM:SS value is 00:00.
  function automatic logic time_is_zero(input logic [15:0] t);
    return (t == 16'd0);
  endfunction

endpackage

// File: rtl/timer_digits_if.sv
// Interface: timer_digits_if
// Purpose: groups the keypad/encoder inputs and the MM:SS display outputs of
//          the countdown timer.
// Signals: D[3:0] digit code, loadn digit strobe (active-low), pgt_1Hz tick
//          level, enablen run/pause (active-low); min_tens, min_ones,
//          sec_tens, sec_ones BCD display digits; counting and done status.
// Modports: master = encoder/driver side, slave = timer side.
interface timer_digits_if;
  logic [3:0] D;
  logic       loadn;
  logic       pgt_1Hz;
  logic       enablen;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       counting;
  logic       done;

  modport master (
    output D, loadn, pgt_1Hz, enablen,
    input  min_tens, min_ones, sec_tens, sec_ones, counting, done
  );

  modport slave (
    input  D, loadn, pgt_1Hz, enablen,
    output min_tens, min_ones, sec_tens, sec_ones, counting, done
  );
endinterface

// File: rtl/timer_digits_bcd_digit_dec.sv
// Module: bcd_digit_dec
// Purpose: one BCD digit of a ripple-borrow decrementer. With borrow_in set,
//          the digit decrements; a zero digit wraps to WRAP and borrows.
// Ports:  digit_in[3:0], borrow_in -> digit_out[3:0], borrow_out.
module bcd_digit_dec
  import timer_digits_pkg::*;
#(
  parameter logic [3:0] WRAP = BCD_NINE
) (
  input  logic [3:0] digit_in,
  input  logic       borrow_in,
  output logic [3:0] digit_out,
  output logic       borrow_out
);

  // Decrement with wrap-and-borrow when a borrow arrives from below.
  always_comb begin
    digit_out  = digit_in;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit_in == 4'd0) begin
        digit_out  = WRAP;
        borrow_out = 1'b1;
      end else begin
        digit_out  = digit_in - 4'd1;
        borrow_out = 1'b0;
      end
    end else begin
      digit_out  = digit_in;
      borrow_out = 1'b0;
    end
  end

endmodule

// File: rtl/timer_digits.sv
// Module: timer_digits
// Purpose: MM:SS kitchen-timer core. Digits are keyed in by shifting left,
//          then counted down once per rising edge of pgt_1Hz until 00:00.
// Ports:  Hz_100_clock  system clock (rising edge)
//         clearn        synchronous active-low reset
//         bus           timer_digits_if.slave (keypad inputs, display outputs)
// Parameter: DIGIT_MAX  largest digit code accepted; larger codes are ignored.
// Build option: TIMER_DIGITS_SEC_CLAMP_EN clamps seconds above 59 to 59 when
//          counting starts; without it such values count down arithmetically.
module timer_digits
  import timer_digits_pkg::*;
#(
  parameter int DIGIT_MAX = 9
) (
  input  logic          Hz_100_clock,
  input  logic          clearn,
  timer_digits_if.slave bus
);

  localparam logic [3:0] DIGIT_MAX_C = 4'(DIGIT_MAX);

  state_t     state_r;
  logic [3:0] min_tens_r, min_ones_r, sec_tens_r, sec_ones_r;
  logic       counting_r, done_r;
  logic       loadn_prev_r, pgt_prev_r;

  logic       load_edge_s, tick_s, digit_ok_s;
  logic [3:0] dec_st_s, dec_so_s, dec_mt_s, dec_mo_s;
  logic       b_so_s, b_st_s, b_mo_s, underflow_s;
  logic [15:0] cur_time_s, dec_time_s;

  assign load_edge_s = ~bus.loadn & loadn_prev_r;
  assign tick_s      = bus.pgt_1Hz & ~pgt_prev_r;
  assign digit_ok_s  = (bus.D <= DIGIT_MAX_C);
  assign cur_time_s  = {min_tens_r, min_ones_r, sec_tens_r, sec_ones_r};
  assign dec_time_s  = {dec_mt_s, dec_mo_s, dec_st_s, dec_so_s};

  // One-second decrement chain, least significant digit first.
  bcd_digit_dec #(.WRAP(BCD_NINE)) u_sec_ones (
    .digit_in(sec_ones_r), .borrow_in(1'b1),
    .digit_out(dec_so_s),  .borrow_out(b_so_s));
  bcd_digit_dec #(.WRAP(BCD_FIVE)) u_sec_tens (
    .digit_in(sec_tens_r), .borrow_in(b_so_s),
    .digit_out(dec_st_s),  .borrow_out(b_st_s));
  bcd_digit_dec #(.WRAP(BCD_NINE)) u_min_ones (
    .digit_in(min_ones_r), .borrow_in(b_st_s),
    .digit_out(dec_mo_s),  .borrow_out(b_mo_s));
  bcd_digit_dec #(.WRAP(BCD_NINE)) u_min_tens (
    .digit_in(min_tens_r), .borrow_in(b_mo_s),
    .digit_out(dec_mt_s),  .borrow_out(underflow_s));

  // FSM, digit register and edge-detect history; reset overrides everything.
  always_ff @(posedge Hz_100_clock) begin
    if (!clearn) begin
      state_r      <= ST_LOAD;
      min_tens_r   <= 4'd0;
      min_ones_r   <= 4'd0;
      sec_tens_r   <= 4'd0;
      sec_ones_r   <= 4'd0;
      counting_r   <= 1'b0;
      done_r       <= 1'b0;
      loadn_prev_r <= 1'b1;
      pgt_prev_r   <= 1'b1;
    end else begin
      loadn_prev_r <= bus.loadn;
      pgt_prev_r   <= bus.pgt_1Hz;
      case (state_r)
        ST_LOAD: begin
          // A key press wins over starting; ticks are never used here.
          if (load_edge_s) begin
            if (digit_ok_s) begin
              {min_tens_r, min_ones_r, sec_tens_r, sec_ones_r} <=
                {min_ones_r, sec_tens_r, sec_ones_r, bus.D};
            end
          end else if (!bus.enablen && !time_is_zero(cur_time_s)) begin
            state_r    <= ST_COUNT;
            counting_r <= 1'b1;
`ifdef TIMER_DIGITS_SEC_CLAMP_EN
            if (sec_tens_r > BCD_FIVE) begin
              sec_tens_r <= BCD_FIVE;
              sec_ones_r <= BCD_NINE;
            end
`endif
          end
        end
        ST_COUNT: begin
          // Pause takes priority over a coincident tick.
          if (bus.enablen) begin
            state_r    <= ST_LOAD;
            counting_r <= 1'b0;
          end else if (tick_s) begin
            if (time_is_zero(dec_time_s) || underflow_s) begin
              // Underflow is unreachable from a nonzero time; park at 00:00.
              {min_tens_r, min_ones_r, sec_tens_r, sec_ones_r} <= 16'd0;
              state_r    <= ST_DONE;
              counting_r <= 1'b0;
              done_r     <= 1'b1;
            end else begin
              {min_tens_r, min_ones_r, sec_tens_r, sec_ones_r} <= dec_time_s;
            end
          end
        end
        ST_DONE: begin
          // A new key clears the display, shifts in the digit and re-arms.
          if (load_edge_s) begin
            {min_tens_r, min_ones_r, sec_tens_r} <= 12'd0;
            sec_ones_r <= digit_ok_s ? bus.D : 4'd0;
            state_r    <= ST_LOAD;
            done_r     <= 1'b0;
          end
        end
        default: begin
          state_r    <= ST_LOAD;
          counting_r <= 1'b0;
          done_r     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.min_tens = min_tens_r;
  assign bus.min_ones = min_ones_r;
  assign bus.sec_tens = sec_tens_r;
  assign bus.sec_ones = sec_ones_r;
  assign bus.counting = counting_r;
  assign bus.done     = done_r;

endmodule
